// File: rtl/vga_layer_arb.sv
// vga_layer_arb: per-pixel layer arbiter with frame-synchronised configuration.
//
// Scan coordinates and layer hit/colour pass through a two-stage registered
// pipeline. The first stage masks hits with the live enable set and captures
// the background. The second stage picks the lowest-index enabled hit.
// Configuration requests are held in a single pending slot. They are copied
// to the live registers only at a frame boundary, so a frame never mixes two
// configurations.
//
// Optional build macro: VGA_LAYER_DEBUG_EN. When it is defined, active-area
// edge pixels are forced to white to outline the visible window.

module vga_layer_arb #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int NUM_LAYERS = 4,
    parameter int LAT        = 2
) (
    input  logic                       clk_vga,
    input  logic                       rst_vga_n,
    input  logic [9:0]                 in_x,
    input  logic [9:0]                 in_y,
    input  logic [NUM_LAYERS-1:0]      lyr_hit,
    input  logic [12*NUM_LAYERS-1:0]   lyr_rgb,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [NUM_LAYERS-1:0]      cfg_en,
    input  logic [11:0]                cfg_bg,
    output logic [3:0]                 out_r,
    output logic [3:0]                 out_g,
    output logic [3:0]                 out_b,
    output logic                       frame_tick,
    output logic [15:0]                frame_cnt,
    output logic                       cfg_applied
);

    localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);

    // The pipeline below is hand-built with exactly two register stages.
    if (LAT != 2) begin : g_lat_check
        $error("vga_layer_arb: LAT must be 2");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } cfg_state_e;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    cfg_state_e                state_q, state_d;
    logic                      cfg_ready_q, cfg_ready_d;
    logic                      cfg_applied_q, cfg_applied_d;
    logic [NUM_LAYERS-1:0]     pend_en_q, pend_en_d;
    logic [11:0]               pend_bg_q, pend_bg_d;
    logic [NUM_LAYERS-1:0]     live_en_q, live_en_d;
    logic [11:0]               live_bg_q, live_bg_d;

    logic [9:0]                prev_x_q, prev_y_q;
    logic                      coord_chg_s;
    logic                      boundary_s;
    logic                      frame_tick_q;
    logic [15:0]               frame_cnt_q;

    logic                      active_s;
    logic                      vld_s1_q;
    logic [NUM_LAYERS-1:0]     hit_s1_q;
    logic [12*NUM_LAYERS-1:0]  rgb_s1_q;
    logic                      act_s1_q;
    logic [11:0]               bg_s1_q;
    logic [11:0]               pix_d, pix_q;

`ifdef VGA_LAYER_DEBUG_EN
    localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE - 1);
    logic                      edge_s;
    logic                      edge_s1_q;
`endif

    // ------------------------------------------------------------------
    // Frame boundary detection
    // ------------------------------------------------------------------
    assign active_s    = (in_x < H_ACT_C) && (in_y < V_ACT_C);
    assign coord_chg_s = (in_x != prev_x_q) || (in_y != prev_y_q);
    assign boundary_s  = coord_chg_s && (in_x == 10'd0) && (in_y == V_ACT_C);

    // Track previous coordinate, frame pulse and frame counter.
    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            prev_x_q     <= 10'h3FF;
            prev_y_q     <= 10'h3FF;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 16'h0000;
        end else begin
            prev_x_q     <= in_x;
            prev_y_q     <= in_y;
            frame_tick_q <= boundary_s;
            frame_cnt_q  <= boundary_s ? (frame_cnt_q + 16'd1) : frame_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Configuration controller
    // ------------------------------------------------------------------
    // Next-state logic: accept into the pending slot, apply at a boundary.
    always_comb begin
        state_d       = state_q;
        pend_en_d     = pend_en_q;
        pend_bg_d     = pend_bg_q;
        live_en_d     = live_en_q;
        live_bg_d     = live_bg_q;
        cfg_applied_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A request landing on a boundary cycle is only captured here.
                // It waits for the next boundary to go live.
                if (cfg_valid && cfg_ready_q) begin
                    pend_en_d = cfg_en;
                    pend_bg_d = cfg_bg;
                    state_d   = ST_PEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (boundary_s) begin
                    live_en_d     = pend_en_q;
                    live_bg_d     = pend_bg_q;
                    cfg_applied_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d       = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cfg_ready_d = (state_d == ST_IDLE);
    end

    // Configuration state, pending slot and live configuration registers.
    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            state_q       <= ST_IDLE;
            cfg_ready_q   <= 1'b1;
            cfg_applied_q <= 1'b0;
            pend_en_q     <= {NUM_LAYERS{1'b0}};
            pend_bg_q     <= 12'h000;
            live_en_q     <= {NUM_LAYERS{1'b1}};
            live_bg_q     <= 12'h000;
        end else begin
            state_q       <= state_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_applied_q <= cfg_applied_d;
            pend_en_q     <= pend_en_d;
            pend_bg_q     <= pend_bg_d;
            live_en_q     <= live_en_d;
            live_bg_q     <= live_bg_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
`ifdef VGA_LAYER_DEBUG_EN
    assign edge_s = (in_x == 10'd0) || (in_x == H_LAST_C) ||
                    (in_y == 10'd0) || (in_y == V_LAST_C);

    // Carry the edge flag alongside the stage-1 pixel.
    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            edge_s1_q <= 1'b0;
        end else begin
            edge_s1_q <= edge_s;
        end
    end
`endif

    // Stage 1: mask hits with the live enables and capture the background.
    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            vld_s1_q <= 1'b0;
            hit_s1_q <= {NUM_LAYERS{1'b0}};
            rgb_s1_q <= {(12*NUM_LAYERS){1'b0}};
            act_s1_q <= 1'b0;
            bg_s1_q  <= 12'h000;
        end else begin
            vld_s1_q <= 1'b1;
            hit_s1_q <= lyr_hit & live_en_q;
            rgb_s1_q <= lyr_rgb;
            act_s1_q <= active_s;
            bg_s1_q  <= live_bg_q;
        end
    end

    // Stage 2 select: blanking, optional border, else the lowest-index hit.
    always_comb begin
        pix_d = 12'h000;
        if (!(vld_s1_q && act_s1_q)) begin
            pix_d = 12'h000;
`ifdef VGA_LAYER_DEBUG_EN
        end else if (edge_s1_q) begin
            pix_d = 12'hFFF;
`endif
        end else begin
            pix_d = bg_s1_q;
            // Walk from the lowest priority up so index 0 is applied last.
            for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
                pix_d = hit_s1_q[k] ? rgb_s1_q[12*k +: 12] : pix_d;
            end
        end
    end

    // Stage 2: registered output pixel.
    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            pix_q <= 12'h000;
        end else begin
            pix_q <= pix_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_r       = pix_q[11:8];
    assign out_g       = pix_q[7:4];
    assign out_b       = pix_q[3:0];
    assign frame_tick  = frame_tick_q;
    assign frame_cnt   = frame_cnt_q;
    assign cfg_ready   = cfg_ready_q;
    assign cfg_applied = cfg_applied_q;

endmodule

// File: tb/tb_vga_layer_arb.sv
// Testbench for vga_layer_arb: scoreboard of expected pixels plus a small
// reference model of the frame and configuration behaviour.
module tb_vga_layer_arb;

    logic        clk_vga = 1'b0;
    logic        rst_vga_n;
    logic [9:0]  in_x, in_y;
    logic [3:0]  lyr_hit;
    logic [47:0] lyr_rgb;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_en;
    logic [11:0] cfg_bg;
    logic [3:0]  out_r, out_g, out_b;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic        cfg_applied;

    // layer3=ABC, layer2=0F0, layer1=F00, layer0=123
    localparam logic [47:0] RGB_A = 48'hABC0F0F00123;

    vga_layer_arb dut (
        .clk_vga     (clk_vga),
        .rst_vga_n   (rst_vga_n),
        .in_x        (in_x),
        .in_y        (in_y),
        .lyr_hit     (lyr_hit),
        .lyr_rgb     (lyr_rgb),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_en      (cfg_en),
        .cfg_bg      (cfg_bg),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .frame_tick  (frame_tick),
        .frame_cnt   (frame_cnt),
        .cfg_applied (cfg_applied)
    );

    always #5 clk_vga = ~clk_vga;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    // reference model state
    logic [3:0]  m_live_en, m_pend_en;
    logic [11:0] m_live_bg, m_pend_bg;
    logic        m_pend, m_tick, m_applied;
    logic [15:0] m_cnt;
    logic [9:0]  m_prev_x, m_prev_y;
    // inputs driven in the previous cycle
    logic [9:0]  p_x, p_y;
    logic        p_valid;
    logic [3:0]  p_en;
    logic [11:0] p_bg;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_pix(input logic [9:0] x, input logic [9:0] y,
                                            input logic [3:0] hit, input logic [47:0] rgb);
        logic [47:0] r;
        r = rgb;
        if (!(x < 10'd640 && y < 10'd480)) return 12'h000;
`ifdef VGA_LAYER_DEBUG_EN
        if (x == 10'd0 || x == 10'd639 || y == 10'd0 || y == 10'd479) return 12'hFFF;
`endif
        for (int k = 0; k < 4; k++) begin
            if (hit[k] && m_live_en[k]) return r[12*k +: 12];
        end
        return m_live_bg;
    endfunction

    // Advance the model across one clock edge using last cycle's inputs.
    task automatic model_edge();
        logic bnd;
        bnd = ((p_x != m_prev_x) || (p_y != m_prev_y)) && (p_x == 10'd0) && (p_y == 10'd480);
        m_prev_x  = p_x;
        m_prev_y  = p_y;
        m_tick    = bnd;
        if (bnd) m_cnt = m_cnt + 16'd1;
        m_applied = 1'b0;
        if (!m_pend) begin
            if (p_valid) begin
                m_pend    = 1'b1;
                m_pend_en = p_en;
                m_pend_bg = p_bg;
            end
        end else if (bnd) begin
            m_live_en = m_pend_en;
            m_live_bg = m_pend_bg;
            m_pend    = 1'b0;
            m_applied = 1'b1;
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [3:0] hit,
                         input logic [47:0] rgb, input logic v, input logic [3:0] en,
                         input logic [11:0] bg);
        in_x = x; in_y = y; lyr_hit = hit; lyr_rgb = rgb;
        cfg_valid = v; cfg_en = en; cfg_bg = bg;
        p_x = x; p_y = y; p_valid = v; p_en = en; p_bg = bg;
        exp_q.push_back(exp_pix(x, y, hit, rgb));
    endtask

    // One pixel clock: check outputs of the edge just taken, then drive.
    task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic [3:0] hit,
                       input logic v, input logic [3:0] en, input logic [11:0] bg);
        logic [11:0] e;
        @(posedge clk_vga);
        #1;
        model_edge();
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check_eq("pix", {4'h0, out_r, out_g, out_b}, {4'h0, e});
        end
        check_eq("frame_tick", {15'd0, frame_tick}, {15'd0, m_tick});
        check_eq("frame_cnt", frame_cnt, m_cnt);
        check_eq("cfg_ready", {15'd0, cfg_ready}, {15'd0, ~m_pend});
        check_eq("cfg_applied", {15'd0, cfg_applied}, {15'd0, m_applied});
        drive(x, y, hit, RGB_A, v, en, bg);
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic [3:0] hit);
        cyc(x, y, hit, 1'b0, 4'h0, 12'h000);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset();
        @(posedge clk_vga);
        #1;
        rst_vga_n = 1'b0;
        #1;
        check_eq("rst_pix", {4'h0, out_r, out_g, out_b}, 16'h0000);
        check_eq("rst_tick", {15'd0, frame_tick}, 16'd0);
        check_eq("rst_fcnt", frame_cnt, 16'd0);
        check_eq("rst_applied", {15'd0, cfg_applied}, 16'd0);
        check_eq("rst_ready", {15'd0, cfg_ready}, 16'd1);
        m_live_en = 4'hF; m_live_bg = 12'h000; m_pend = 1'b0;
        m_pend_en = 4'h0; m_pend_bg = 12'h000;
        m_cnt = 16'd0; m_tick = 1'b0; m_applied = 1'b0;
        m_prev_x = 10'd700; m_prev_y = 10'd0;
        exp_q.delete();
        exp_q.push_back(12'h000);
        drive(10'd700, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
        repeat (2) @(posedge clk_vga);
        #1;
        rst_vga_n = 1'b1;
    endtask

    initial begin
        rst_vga_n = 1'b0;
        in_x = 10'd700; in_y = 10'd0; lyr_hit = 4'h0; lyr_rgb = 48'h0;
        cfg_valid = 1'b0; cfg_en = 4'h0; cfg_bg = 12'h000;
        do_reset();

        // no hits, default background; boundaries with held coordinates
        px(10'd10, 10'd10, 4'h0);
        px(10'd11, 10'd10, 4'h0);
        px(10'd700, 10'd10, 4'h0);
        px(10'd0, 10'd480, 4'h0);
        px(10'd0, 10'd480, 4'h0);
        px(10'd0, 10'd480, 4'h0);
        px(10'd1, 10'd480, 4'h0);
        px(10'd0, 10'd0, 4'h0);
        px(10'd10, 10'd10, 4'h0);
        px(10'd0, 10'd480, 4'h0);
        px(10'd5, 10'd480, 4'h0);

        // priority arbitration
        px(10'd10, 10'd10, 4'b0110);
        px(10'd700, 10'd10, 4'b0110);
        px(10'd10, 10'd10, 4'b1111);
        px(10'd10, 10'd11, 4'b1000);
        px(10'd10, 10'd12, 4'b0000);

        // mid-frame config request, held until the boundary
        cyc(10'd20, 10'd100, 4'b0110, 1'b1, 4'b1101, 12'h00F);
        px(10'd21, 10'd100, 4'b0110);
        px(10'd22, 10'd100, 4'b0000);
        cyc(10'd23, 10'd100, 4'b0110, 1'b1, 4'b0001, 12'hFFF);
        px(10'd639, 10'd479, 4'b0000);
        px(10'd0, 10'd480, 4'b0110);
        px(10'd1, 10'd480, 4'b0000);
        px(10'd10, 10'd10, 4'b0110);
        px(10'd11, 10'd10, 4'b0000);
        px(10'd12, 10'd10, 4'b1001);

        // request on the boundary cycle waits for the following boundary
        px(10'd639, 10'd479, 4'b0000);
        cyc(10'd0, 10'd480, 4'b0110, 1'b1, 4'b1111, 12'h0A0);
        px(10'd1, 10'd480, 4'b0000);
        px(10'd10, 10'd10, 4'b0110);
        px(10'd11, 10'd10, 4'b0000);
        cyc(10'd12, 10'd10, 4'b0000, 1'b1, 4'b0001, 12'hFFF);
        px(10'd0, 10'd480, 4'b0000);
        px(10'd1, 10'd480, 4'b0000);
        px(10'd10, 10'd10, 4'b0110);
        px(10'd11, 10'd10, 4'b0000);

        // reset while a request is pending
        cyc(10'd20, 10'd200, 4'b0000, 1'b1, 4'b0000, 12'h555);
        px(10'd21, 10'd200, 4'b0110);
        do_reset();
        px(10'd10, 10'd10, 4'b0110);
        px(10'd11, 10'd10, 4'b0000);
        px(10'd0, 10'd480, 4'b0000);
        px(10'd10, 10'd10, 4'b0110);
        px(10'd11, 10'd10, 4'b0000);

        // active-area edge pixels (white only in the debug build)
        px(10'd0, 10'd5, 4'b1111);
        px(10'd639, 10'd5, 4'b0110);
        px(10'd5, 10'd479, 4'b0000);
        px(10'd5, 10'd5, 4'b0110);

        // flush the pipeline
        px(10'd700, 10'd0, 4'b0000);
        px(10'd700, 10'd0, 4'b0000);
        px(10'd700, 10'd0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
